// File: rtl/spi_dac_multi_driver.sv
// spi_dac_multi_driver
// Multi-channel SPI mode-0 master for MCP48x2-style DACs. One multi-channel
// sample is taken per handshake, one 16-bit command word is shifted out per
// channel, and an optional LDAC strobe updates all channel outputs together.
//
// Handshake: a sample is transferred on a rising clk_25mhz edge where
// sample_valid && sample_ready. sample_ready is only ever high in IDLE.
// sample_valid and sample_in are ignored while busy. sample_ready rises on the
// edge that completes a frame, so a held sample_valid is accepted one edge later.
module spi_dac_multi_driver #(
   parameter int CLK_DIV   = 6,
   parameter int NUM_CH    = 2,
   parameter int SAMPLE_W  = 16,
   parameter int DAC_BITS  = 12,
   parameter int SIGNED_IN = 0,
   parameter int GAIN_2X   = 0,
   parameter int LDAC_EN   = 1
) (
   input  logic                       clk_25mhz,
   input  logic                       reset_n,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
   output logic                       spi_sclk_out,
   output logic                       spi_mosi_out,
   output logic                       spi_cs_n_out,
   output logic                       dac_ldac_n_out,
   output logic                       busy,
   output logic                       frame_done
);

   // Reject illegal parameter combinations at elaboration time.
   generate
      if (CLK_DIV < 2) begin : g_bad_clk_div
         $error("spi_dac_multi_driver: CLK_DIV must be >= 2");
      end
      if (NUM_CH != 1 && NUM_CH != 2) begin : g_bad_num_ch
         $error("spi_dac_multi_driver: NUM_CH must be 1 or 2");
      end
      if (DAC_BITS != 8 && DAC_BITS != 10 && DAC_BITS != 12) begin : g_bad_dac_bits
         $error("spi_dac_multi_driver: DAC_BITS must be 8, 10 or 12");
      end
      if (DAC_BITS > SAMPLE_W) begin : g_bad_sample_w
         $error("spi_dac_multi_driver: DAC_BITS must not exceed SAMPLE_W");
      end
   endgenerate

   // The LDAC phase is twice as long as the others, so the divider must reach 2*CLK_DIV-1.
   localparam int DIV_W = $clog2(2 * CLK_DIV);

   // Frame completion is signalled on the edge that returns to IDLE, so no
   // separate resting DONE state is needed.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CS_SETUP = 3'd1,
      SHIFT    = 3'd2,
      CS_HOLD  = 3'd3,
      GAP      = 3'd4,
      LDAC     = 3'd5
   } state_t;

   state_t                       state_q, state_n;
   logic [DIV_W-1:0]             div_q, div_n;
   logic [3:0]                   bit_q, bit_n;
   logic                         ch_q, ch_n, nxt_ch;
   logic [15:0]                  shreg_q, shreg_n, word;
   logic [NUM_CH*SAMPLE_W-1:0]   smp_q, smp_n;
   logic                         sclk_q, sclk_n;
   logic                         mosi_q, mosi_n;
   logic                         cs_n_q, cs_n_n;
   logic                         ldac_n_q, ldac_n_n;
   logic                         ready_q, ready_n;
   logic                         busy_q, busy_n;
   logic                         done_q, done_n;
   logic                         phase_end;

   // Build the DAC command word for one channel from its raw sample.
   function automatic logic [15:0] make_word(input logic [SAMPLE_W-1:0] s, input logic chan);
      logic [SAMPLE_W-1:0] t;
      logic [DAC_BITS-1:0] d;
      logic [11:0]         f;
      t = s;
      if (SIGNED_IN != 0) t[SAMPLE_W-1] = ~t[SAMPLE_W-1];
      d = t[SAMPLE_W-1 -: DAC_BITS];
      f = 12'(d) << (12 - DAC_BITS);
      return {chan, 1'b0, (GAIN_2X != 0) ? 1'b0 : 1'b1, 1'b1, f};
   endfunction

   // State and registered-output register.
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         ch_q     <= 1'b0;
         shreg_q  <= '0;
         smp_q    <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         ldac_n_q <= 1'b1;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         div_q    <= div_n;
         bit_q    <= bit_n;
         ch_q     <= ch_n;
         shreg_q  <= shreg_n;
         smp_q    <= smp_n;
         sclk_q   <= sclk_n;
         mosi_q   <= mosi_n;
         cs_n_q   <= cs_n_n;
         ldac_n_q <= ldac_n_n;
         ready_q  <= ready_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
      end
   end

   // Next-state, timebase and next-output logic.
   always_comb begin
      state_n   = state_q;
      div_n     = '0;
      bit_n     = bit_q;
      ch_n      = ch_q;
      shreg_n   = shreg_q;
      smp_n     = smp_q;
      sclk_n    = sclk_q;
      mosi_n    = mosi_q;
      cs_n_n    = cs_n_q;
      ldac_n_n  = ldac_n_q;
      ready_n   = ready_q;
      busy_n    = busy_q;
      done_n    = 1'b0;
      word      = '0;
      nxt_ch    = ch_q + 1'b1;
      phase_end = (state_q == LDAC) ? (div_q == DIV_W'(2 * CLK_DIV - 1))
                                    : (div_q == DIV_W'(CLK_DIV - 1));

      if (state_q != IDLE) div_n = phase_end ? '0 : div_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (sample_valid && ready_q) begin
               word    = make_word(sample_in[SAMPLE_W-1:0], 1'b0);
               smp_n   = sample_in;
               ch_n    = 1'b0;
               shreg_n = word;
               mosi_n  = word[15];
               cs_n_n  = 1'b0;
               ready_n = 1'b0;
               busy_n  = 1'b1;
               state_n = CS_SETUP;
            end else begin
               ready_n = 1'b1;
            end
         end
         CS_SETUP: begin
            if (phase_end) begin
               sclk_n  = 1'b1;
               bit_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (phase_end) begin
               if (sclk_q) begin
                  // Falling edge: present the next bit so it is stable at the next rise.
                  sclk_n  = 1'b0;
                  mosi_n  = shreg_q[14];
                  shreg_n = {shreg_q[14:0], 1'b0};
               end else if (bit_q == 4'd15) begin
                  state_n = CS_HOLD;
               end else begin
                  sclk_n = 1'b1;
                  bit_n  = bit_q + 1'b1;
               end
            end
         end
         CS_HOLD: begin
            if (phase_end) begin
               cs_n_n  = 1'b1;
               mosi_n  = 1'b0;
               state_n = GAP;
            end
         end
         GAP: begin
            if (phase_end) begin
               if (int'(ch_q) < NUM_CH - 1) begin
                  word    = make_word(smp_q[SAMPLE_W*int'(nxt_ch) +: SAMPLE_W], nxt_ch);
                  ch_n    = nxt_ch;
                  shreg_n = word;
                  mosi_n  = word[15];
                  cs_n_n  = 1'b0;
                  state_n = CS_SETUP;
               end else if (LDAC_EN != 0) begin
                  ldac_n_n = 1'b0;
                  state_n  = LDAC;
               end else begin
                  done_n  = 1'b1;
                  ready_n = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end
            end
         end
         LDAC: begin
            if (phase_end) begin
               ldac_n_n = 1'b1;
               done_n   = 1'b1;
               ready_n  = 1'b1;
               busy_n   = 1'b0;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign sample_ready   = ready_q;
   assign spi_sclk_out   = sclk_q;
   assign spi_mosi_out   = mosi_q;
   assign spi_cs_n_out   = cs_n_q;
   assign dac_ldac_n_out = ldac_n_q;
   assign busy           = busy_q;
   assign frame_done     = done_q;

endmodule

// File: tb/tb_spi_dac_multi_driver.sv
// tb_spi_dac_multi_driver
// Four parameterisations of the DAC driver share clock and reset; one is
// selected at a time and its pins are decoded by a single SPI monitor.
module tb_spi_dac_multi_driver;

   logic        clk_25mhz = 1'b0;
   logic        reset_n   = 1'b0;
   logic        valid     = 1'b0;
   logic [31:0] bus       = '0;
   logic [1:0]  sel       = 2'd0;
   logic        mon_clear = 1'b0;

   wire [3:0] sclk_w, mosi_w, cs_w, ldac_w, busy_w, ready_w, fd_w;
   wire obs_sclk  = sclk_w[sel];
   wire obs_mosi  = mosi_w[sel];
   wire obs_cs_n  = cs_w[sel];
   wire obs_ldac  = ldac_w[sel];
   wire obs_busy  = busy_w[sel];
   wire obs_ready = ready_w[sel];
   wire obs_fd    = fd_w[sel];

   int n_tests = 0;
   int n_fail  = 0;

   // clock / reset
   always #20 clk_25mhz = ~clk_25mhz;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   spi_dac_multi_driver u0 (
      .clk_25mhz(clk_25mhz), .reset_n(reset_n), .sample_valid(valid && sel == 2'd0),
      .sample_ready(ready_w[0]), .sample_in(bus), .spi_sclk_out(sclk_w[0]),
      .spi_mosi_out(mosi_w[0]), .spi_cs_n_out(cs_w[0]), .dac_ldac_n_out(ldac_w[0]),
      .busy(busy_w[0]), .frame_done(fd_w[0]));

   spi_dac_multi_driver #(.SIGNED_IN(1)) u1 (
      .clk_25mhz(clk_25mhz), .reset_n(reset_n), .sample_valid(valid && sel == 2'd1),
      .sample_ready(ready_w[1]), .sample_in(bus), .spi_sclk_out(sclk_w[1]),
      .spi_mosi_out(mosi_w[1]), .spi_cs_n_out(cs_w[1]), .dac_ldac_n_out(ldac_w[1]),
      .busy(busy_w[1]), .frame_done(fd_w[1]));

   spi_dac_multi_driver #(.NUM_CH(1), .DAC_BITS(8), .LDAC_EN(0)) u2 (
      .clk_25mhz(clk_25mhz), .reset_n(reset_n), .sample_valid(valid && sel == 2'd2),
      .sample_ready(ready_w[2]), .sample_in(bus[15:0]), .spi_sclk_out(sclk_w[2]),
      .spi_mosi_out(mosi_w[2]), .spi_cs_n_out(cs_w[2]), .dac_ldac_n_out(ldac_w[2]),
      .busy(busy_w[2]), .frame_done(fd_w[2]));

   spi_dac_multi_driver #(.GAIN_2X(1), .CLK_DIV(2)) u3 (
      .clk_25mhz(clk_25mhz), .reset_n(reset_n), .sample_valid(valid && sel == 2'd3),
      .sample_ready(ready_w[3]), .sample_in(bus), .spi_sclk_out(sclk_w[3]),
      .spi_mosi_out(mosi_w[3]), .spi_cs_n_out(cs_w[3]), .dac_ldac_n_out(ldac_w[3]),
      .busy(busy_w[3]), .frame_done(fd_w[3]));

   // SPI monitor: decodes cs_n windows, counts edges and strobes (sampled on negedge)
   logic [15:0] words[$];
   int          rises_q[$];
   int          acc_q[$];
   int          fd_q[$];
   logic [15:0] cur_word = '0;
   int          cur_rises = 0;
   int          ldac_low = 0;
   int          stray = 0;
   int          last_rise = -1;
   int          period = 0;
   int          cyc = 0;
   logic        prev_sclk = 1'b0;
   logic        prev_cs_n = 1'b1;

   always @(negedge clk_25mhz) begin
      cyc = cyc + 1;
      if (mon_clear) begin
         words.delete(); rises_q.delete(); acc_q.delete(); fd_q.delete();
         cur_word = '0; cur_rises = 0; ldac_low = 0; stray = 0; last_rise = -1; period = 0;
      end else begin
         if (!obs_cs_n && prev_cs_n) begin
            cur_word  = '0;
            cur_rises = 0;
         end
         if (obs_sclk && !prev_sclk) begin
            if (!obs_cs_n) begin
               cur_word  = {cur_word[14:0], obs_mosi};
               cur_rises = cur_rises + 1;
            end else begin
               stray = stray + 1;
            end
            if (last_rise >= 0) period = cyc - last_rise;
            last_rise = cyc;
         end
         if (obs_cs_n && !prev_cs_n) begin
            words.push_back(cur_word);
            rises_q.push_back(cur_rises);
         end
         if (!obs_ldac) ldac_low = ldac_low + 1;
         if (obs_fd) fd_q.push_back(cyc);
         if (valid && obs_ready) acc_q.push_back(cyc + 1);
      end
      prev_sclk = obs_sclk;
      prev_cs_n = obs_cs_n;
   end

   // scoreboard check
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic clear_mon();
      @(posedge clk_25mhz); #1 mon_clear = 1'b1;
      @(negedge clk_25mhz); #1 mon_clear = 1'b0;
   endtask

   task automatic send(input logic [31:0] d);
      int i;
      @(posedge clk_25mhz); #1;
      bus   = d;
      valid = 1'b1;
      for (i = 0; i < 100; i++) begin
         @(negedge clk_25mhz);
         if (obs_ready) break;
      end
      check("ready_seen", {31'd0, obs_ready}, 32'd1);
      @(posedge clk_25mhz); #1 valid = 1'b0;
   endtask

   task automatic wait_fd(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_25mhz);
         if (fd_q.size() >= n) break;
      end
      check("frame_done_seen", {31'd0, fd_q.size() >= n}, 32'd1);
   endtask

   task automatic wait_acc(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_25mhz);
         if (acc_q.size() >= n) break;
      end
      check("accept_seen", {31'd0, acc_q.size() >= n}, 32'd1);
   endtask

   task automatic check_word(input string tag, input int idx, input logic [15:0] exp);
      if (words.size() > idx) begin
         check(tag, {16'd0, words[idx]}, {16'd0, exp});
         check({tag, "_rises"}, rises_q[idx], 32'd16);
      end else begin
         check({tag, "_present"}, words.size(), idx + 1);
      end
   endtask

   int lat;

   initial begin
      // reset state of every instance
      repeat (3) @(posedge clk_25mhz);
      #1;
      check("rst_ready", {28'd0, ready_w}, 32'h0);
      check("rst_cs_n",  {28'd0, cs_w},    32'hF);
      check("rst_sclk",  {28'd0, sclk_w},  32'h0);
      check("rst_mosi",  {28'd0, mosi_w},  32'h0);
      check("rst_ldac",  {28'd0, ldac_w},  32'hF);
      check("rst_busy",  {28'd0, busy_w},  32'h0);
      check("rst_done",  {28'd0, fd_w},    32'h0);
      reset_n = 1'b1;
      @(negedge clk_25mhz);
      check("ready_before_edge", {28'd0, ready_w}, 32'h0);
      @(negedge clk_25mhz);
      check("ready_after_edge", {28'd0, ready_w}, 32'hF);

      // defaults: two channels, LDAC pulse, 432-cycle frame
      sel = 2'd0;
      clear_mon();
      send(32'hFFF0_8000);
      #1 check("busy_after_accept", {31'd0, obs_busy}, 32'd1);
      wait_fd(1, 2000);
      check_word("def_w0", 0, 16'h3800);
      check_word("def_w1", 1, 16'hBFFF);
      check("def_windows", words.size(), 32'd2);
      check("def_ldac_low", ldac_low, 32'd12);
      check("def_period", period, 32'd12);
      check("def_stray", stray, 32'd0);
      lat = (fd_q.size() > 0 && acc_q.size() > 0) ? fd_q[0] - acc_q[0] : -1;
      check("def_latency", lat, 32'd432);
      @(negedge clk_25mhz);
      check("def_done_pulse", {31'd0, obs_fd}, 32'd0);
      check("def_busy_idle", {31'd0, obs_busy}, 32'd0);

      // signed input conversion
      sel = 2'd1;
      clear_mon();
      send(32'h8000_0000);
      wait_fd(1, 2000);
      check_word("sgn_w0", 0, 16'h3800);
      check_word("sgn_w1", 1, 16'hB000);

      // 8-bit DAC, single channel, no LDAC
      sel = 2'd2;
      clear_mon();
      send(32'h0000_ABCD);
      wait_fd(1, 2000);
      check_word("b8_w0", 0, 16'h3AB0);
      check("b8_windows", words.size(), 32'd1);
      check("b8_ldac_low", ldac_low, 32'd0);
      lat = (fd_q.size() > 0 && acc_q.size() > 0) ? fd_q[0] - acc_q[0] : -1;
      check("b8_latency", lat, 32'd210);

      // back-to-back with sample_valid held and sample_in toggled mid-frame
      sel = 2'd0;
      clear_mon();
      @(posedge clk_25mhz); #1;
      bus   = 32'h5678_1234;
      valid = 1'b1;
      wait_acc(1, 100);
      #1 bus = 32'hAAAA_5555;
      repeat (200) @(posedge clk_25mhz);
      #1 bus = 32'h0010_FED0;
      wait_acc(2, 2000);
      #1;
      bus   = 32'h3333_CCCC;
      valid = 1'b0;
      wait_fd(2, 2000);
      check_word("b2b_w0", 0, 16'h3123);
      check_word("b2b_w1", 1, 16'hB567);
      check_word("b2b_w2", 2, 16'h3FED);
      check_word("b2b_w3", 3, 16'hB001);
      if (acc_q.size() >= 2 && fd_q.size() >= 1)
         check("b2b_accept_edge", acc_q[1], fd_q[0] + 1);
      else
         check("b2b_accept_count", acc_q.size(), 32'd2);

      // asynchronous reset in the 7th bit of channel 1
      clear_mon();
      send(32'hFFF0_8000);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk_25mhz);
         if (words.size() == 1 && cur_rises == 7 && obs_sclk) break;
      end
      check("rst7_reached", {31'd0, words.size() == 1 && cur_rises == 7}, 32'd1);
      check("rst7_mosi_before", {31'd0, obs_mosi}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst7_cs_n", {31'd0, obs_cs_n}, 32'd1);
      check("rst7_sclk", {31'd0, obs_sclk}, 32'd0);
      check("rst7_mosi", {31'd0, obs_mosi}, 32'd0);
      check("rst7_busy", {31'd0, obs_busy}, 32'd0);
      @(posedge clk_25mhz); #1 reset_n = 1'b1;
      @(negedge clk_25mhz);
      check("rst7_ready_low", {31'd0, obs_ready}, 32'd0);
      @(negedge clk_25mhz);
      check("rst7_ready_high", {31'd0, obs_ready}, 32'd1);
      clear_mon();
      send(32'hFFF0_8000);
      wait_fd(1, 2000);
      check_word("rst7_w0", 0, 16'h3800);
      check_word("rst7_w1", 1, 16'hBFFF);

      // 2x gain and fast SCLK
      sel = 2'd3;
      clear_mon();
      send(32'h0000_1230);
      wait_fd(1, 1000);
      check_word("g2_w0", 0, 16'h1123);
      check_word("g2_w1", 1, 16'h9000);
      check("g2_period", period, 32'd4);
      check("g2_ldac_low", ldac_low, 32'd4);
      lat = (fd_q.size() > 0 && acc_q.size() > 0) ? fd_q[0] - acc_q[0] : -1;
      check("g2_latency", lat, 32'd144);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
